// File: rtl/bus_register_bank_if.sv
// Microprocessor data-bus bundle seen by a bus-mapped peripheral.
// The master drives address, write data and strobes. The slave returns
// registered read data with an output-enable flag.
interface bus_register_bank_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] BUS_ADDR;
  logic [DATA_WIDTH-1:0] BUS_DATA_IN;
  logic                  BUS_WE;
  logic                  BUS_RE;
  logic [DATA_WIDTH-1:0] BUS_DATA_OUT;
  logic                  BUS_DATA_OE;

  modport master (
    output BUS_ADDR,
    output BUS_DATA_IN,
    output BUS_WE,
    output BUS_RE,
    input  BUS_DATA_OUT,
    input  BUS_DATA_OE
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_DATA_IN,
    input  BUS_WE,
    input  BUS_RE,
    output BUS_DATA_OUT,
    output BUS_DATA_OE
  );
endinterface

// File: rtl/bus_register_bank.sv
// Bus-mapped peripheral register bank.
// Map, as offsets from BASE_ADDR:
//   0 .. NUM_REGS-1 : REG[i], read/write, each with a one-cycle write pulse
//   NUM_REGS        : STATUS, sticky rising-edge event flags, write-1-to-clear
//   NUM_REGS+1      : IRQ_MASK, read/write
// Reads answer one cycle after the sampling edge. Any access outside the map
// is ignored. The bus interface must use the same ADDR_WIDTH and DATA_WIDTH
// as this module.
module bus_register_bank #(
  parameter int unsigned           BASE_ADDR     = 'h90,
  parameter int unsigned           ADDR_WIDTH    = 8,
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter int unsigned           NUM_REGS      = 4,
  parameter int unsigned           NUM_EVENTS    = 8,
  parameter logic [DATA_WIDTH-1:0] REG_RESET_VAL = '0
) (
  input  logic                           CLK,
  input  logic                           RESET,
  bus_register_bank_if.slave             bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_OUT,
  output logic [NUM_REGS-1:0]            REG_WR_PULSE,
  input  logic [NUM_EVENTS-1:0]          EVENT_IN,
  output logic                           IRQ
);

  // Reject configurations whose map would not fit or whose events exceed a word.
  generate
    if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num_regs
      $error("bus_register_bank: NUM_REGS must be in 1..16");
    end
    if (NUM_EVENTS < 1 || NUM_EVENTS > DATA_WIDTH) begin : g_bad_num_events
      $error("bus_register_bank: NUM_EVENTS must be in 1..DATA_WIDTH");
    end
    if ((longint'(BASE_ADDR) + longint'(NUM_REGS) + 1) >
        ((longint'(1) << ADDR_WIDTH) - 1)) begin : g_bad_base_addr
      $error("bus_register_bank: register map does not fit in the address space");
    end
  endgenerate

  localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STATUS_OFS = ADDR_WIDTH'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] MASK_OFS   = ADDR_WIDTH'(NUM_REGS + 1);
  // Only the low NUM_EVENTS bits of a word carry event information.
  localparam logic [DATA_WIDTH-1:0] EVENT_BITS = DATA_WIDTH'({NUM_EVENTS{1'b1}});

  logic [ADDR_WIDTH-1:0]          offset;
  logic                           addr_hit;
  logic                           wr_hit;
  logic                           rd_hit;
  logic                           status_wr;
  logic                           mask_wr;

  logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat;
  logic [NUM_REGS-1:0]            pulse_vec;

  logic [NUM_EVENTS-1:0]          event_q_reg;
  logic [NUM_EVENTS-1:0]          rise;
  logic [DATA_WIDTH-1:0]          w1c;
  logic [DATA_WIDTH-1:0]          status_reg;
  logic [DATA_WIDTH-1:0]          status_next;
  logic [DATA_WIDTH-1:0]          mask_reg;
  logic                           irq_reg;

  logic [DATA_WIDTH-1:0]          rd_value;
  logic [DATA_WIDTH-1:0]          data_out_reg;
  logic                           oe_reg;

  // Address decode. The lower-bound test keeps addresses below BASE_ADDR from
  // wrapping into the map through the subtraction.
  assign offset    = bus.BUS_ADDR - BASE;
  assign addr_hit  = (bus.BUS_ADDR >= BASE) && (offset <= MASK_OFS);
  assign wr_hit    = bus.BUS_WE && addr_hit;
  // When both strobes are high, the write wins and no read response is given.
  assign rd_hit    = bus.BUS_RE && !bus.BUS_WE && addr_hit;
  assign status_wr = wr_hit && (offset == STATUS_OFS);
  assign mask_wr   = wr_hit && (offset == MASK_OFS);

  // One slice per output register: storage plus its write strobe.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] value_reg;
      logic                  pulse_reg;
      logic                  sel;

      assign sel = wr_hit && (offset == ADDR_WIDTH'(gi));

      // Capture write data. Pulse on every write, even when the value is unchanged.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          value_reg <= REG_RESET_VAL;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= sel;
          if (sel) begin
            value_reg <= bus.BUS_DATA_IN;
          end
        end
      end

      assign reg_flat[gi*DATA_WIDTH +: DATA_WIDTH] = value_reg;
      assign pulse_vec[gi]                         = pulse_reg;
    end
  endgenerate

  assign REG_OUT      = reg_flat;
  assign REG_WR_PULSE = pulse_vec;

  // Detect rising edges. event_q resets to all ones, so a line that is already
  // high when reset is released does not count as an edge.
  assign rise = EVENT_IN & ~event_q_reg;

  // Sticky status: clear the bits written as 1, then OR in new edges so that
  // a set in the same cycle as a clear wins.
  always_comb begin
    w1c         = status_wr ? bus.BUS_DATA_IN : '0;
    status_next = ((status_reg & ~w1c) | DATA_WIDTH'(rise)) & EVENT_BITS;
  end

  // Event history, status flags, interrupt mask and the registered IRQ.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      event_q_reg <= '1;
      status_reg  <= '0;
      mask_reg    <= '0;
      irq_reg     <= 1'b0;
    end else begin
      event_q_reg <= EVENT_IN;
      status_reg  <= status_next;
      if (mask_wr) begin
        mask_reg <= bus.BUS_DATA_IN;
      end
      irq_reg <= |(status_reg & mask_reg & EVENT_BITS);
    end
  end

  assign IRQ = irq_reg;

  // Read mux. STATUS is the value held before this edge, so same-cycle events are excluded.
  always_comb begin
    rd_value = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (offset == ADDR_WIDTH'(i)) begin
        rd_value = reg_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (offset == STATUS_OFS) begin
      rd_value = status_reg;
    end
    if (offset == MASK_OFS) begin
      rd_value = mask_reg;
    end
  end

  // Registered read response. The data is forced to zero whenever OE is low.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_out_reg <= '0;
      oe_reg       <= 1'b0;
    end else begin
      oe_reg       <= rd_hit;
      data_out_reg <= rd_hit ? rd_value : '0;
    end
  end

  assign bus.BUS_DATA_OUT = data_out_reg;
  assign bus.BUS_DATA_OE  = oe_reg;

endmodule

// File: tb/tb_bus_register_bank.sv
// Directed bench for bus_register_bank with the default parameters.
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same
// point, so each check sees the result of the edge just taken.
module tb_bus_register_bank;

  logic        CLK;
  logic        RESET;
  logic [7:0]  EVENT_IN;
  logic [31:0] REG_OUT;
  logic [3:0]  REG_WR_PULSE;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  bus_register_bank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus_if ();

  bus_register_bank #(
    .BASE_ADDR    ('h90),
    .ADDR_WIDTH   (8),
    .DATA_WIDTH   (8),
    .NUM_REGS     (4),
    .NUM_EVENTS   (8),
    .REG_RESET_VAL(8'h00)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .bus         (bus_if),
    .REG_OUT     (REG_OUT),
    .REG_WR_PULSE(REG_WR_PULSE),
    .EVENT_IN    (EVENT_IN),
    .IRQ         (IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    bus_if.BUS_ADDR    = 8'h00;
    bus_if.BUS_DATA_IN = 8'h00;
    bus_if.BUS_WE      = 1'b0;
    bus_if.BUS_RE      = 1'b0;
  endtask

  task automatic drive_write(input logic [7:0] addr, input logic [7:0] data);
    bus_if.BUS_ADDR    = addr;
    bus_if.BUS_DATA_IN = data;
    bus_if.BUS_WE      = 1'b1;
    bus_if.BUS_RE      = 1'b0;
  endtask

  task automatic drive_read(input logic [7:0] addr);
    bus_if.BUS_ADDR    = addr;
    bus_if.BUS_DATA_IN = 8'h00;
    bus_if.BUS_WE      = 1'b0;
    bus_if.BUS_RE      = 1'b1;
  endtask

  task automatic test_reset();
    RESET    = 1'b1;
    EVENT_IN = 8'h00;
    bus_idle();
    tick();
    tick();
    RESET = 1'b0;
    checks++;
    if (REG_OUT !== 32'h0) begin
      errors++; $display("FAIL reset_reg_out: got %h expected %h", REG_OUT, 32'h0);
    end
    checks++;
    if (bus_if.BUS_DATA_OE !== 1'b0 || bus_if.BUS_DATA_OUT !== 8'h00) begin
      errors++; $display("FAIL reset_bus_out: got oe=%b data=%h expected oe=0 data=00", bus_if.BUS_DATA_OE, bus_if.BUS_DATA_OUT);
    end
    checks++;
    if (IRQ !== 1'b0 || REG_WR_PULSE !== 4'b0000) begin
      errors++; $display("FAIL reset_irq_pulse: got irq=%b pulse=%b expected irq=0 pulse=0000", IRQ, REG_WR_PULSE);
    end
    for (int a = 8'h90; a <= 8'h95; a++) begin
      drive_read(8'(a));
      tick();
      checks++;
      if (bus_if.BUS_DATA_OE !== 1'b1 || bus_if.BUS_DATA_OUT !== 8'h00) begin
        errors++; $display("FAIL reset_read_%h: got oe=%b data=%h expected oe=1 data=00", a, bus_if.BUS_DATA_OE, bus_if.BUS_DATA_OUT);
      end
    end
    bus_idle();
    tick();
    checks++;
    if (bus_if.BUS_DATA_OE !== 1'b0) begin
      errors++; $display("FAIL reset_read_end_oe: got %b expected 0", bus_if.BUS_DATA_OE);
    end
    $display("test_reset: done");
  endtask

  task automatic test_write_read();
    drive_write(8'h92, 8'hA5);
    tick();
    checks++;
    if (REG_OUT !== 32'h00A5_0000 || REG_WR_PULSE !== 4'b0100) begin
      errors++; $display("FAIL write_reg2: got reg=%h pulse=%b expected reg=00a50000 pulse=0100", REG_OUT, REG_WR_PULSE);
    end
    bus_idle();
    tick();
    checks++;
    if (REG_WR_PULSE !== 4'b0000 || REG_OUT !== 32'h00A5_0000) begin
      errors++; $display("FAIL write_pulse_end: got reg=%h pulse=%b expected reg=00a50000 pulse=0000", REG_OUT, REG_WR_PULSE);
    end
    drive_read(8'h92);
    tick();
    checks++;
    if (bus_if.BUS_DATA_OE !== 1'b1 || bus_if.BUS_DATA_OUT !== 8'hA5) begin
      errors++; $display("FAIL read_reg2: got oe=%b data=%h expected oe=1 data=a5", bus_if.BUS_DATA_OE, bus_if.BUS_DATA_OUT);
    end
    drive_write(8'h92, 8'hA5);
    tick();
    checks++;
    if (REG_WR_PULSE !== 4'b0100 || bus_if.BUS_DATA_OE !== 1'b0) begin
      errors++; $display("FAIL rewrite_same_pulse: got pulse=%b oe=%b expected pulse=0100 oe=0", REG_WR_PULSE, bus_if.BUS_DATA_OE);
    end
    drive_write(8'h95, 8'h5A);
    tick();
    drive_read(8'h95);
    tick();
    checks++;
    if (bus_if.BUS_DATA_OE !== 1'b1 || bus_if.BUS_DATA_OUT !== 8'h5A || REG_WR_PULSE !== 4'b0000) begin
      errors++; $display("FAIL mask_readback: got oe=%b data=%h pulse=%b expected oe=1 data=5a pulse=0000", bus_if.BUS_DATA_OE, bus_if.BUS_DATA_OUT, REG_WR_PULSE);
    end
    bus_idle();
    tick();
    $display("test_write_read: done");
  endtask

  task automatic test_out_of_range();
    drive_read(8'h96);
    tick();
    checks++;
    if (bus_if.BUS_DATA_OE !== 1'b0 || bus_if.BUS_DATA_OUT !== 8'h00) begin
      errors++; $display("FAIL read_0x96: got oe=%b data=%h expected oe=0 data=00", bus_if.BUS_DATA_OE, bus_if.BUS_DATA_OUT);
    end
    drive_write(8'h8F, 8'hFF);
    tick();
    checks++;
    if (REG_OUT !== 32'h00A5_0000 || REG_WR_PULSE !== 4'b0000) begin
      errors++; $display("FAIL write_0x8f: got reg=%h pulse=%b expected reg=00a50000 pulse=0000", REG_OUT, REG_WR_PULSE);
    end
    drive_read(8'h8F);
    tick();
    checks++;
    if (bus_if.BUS_DATA_OE !== 1'b0) begin
      errors++; $display("FAIL read_0x8f: got oe=%b expected 0", bus_if.BUS_DATA_OE);
    end
    // Both strobes high: the write lands and no read response is given.
    drive_write(8'h91, 8'h11);
    bus_if.BUS_RE = 1'b1;
    tick();
    checks++;
    if (REG_OUT !== 32'h00A5_1100 || REG_WR_PULSE !== 4'b0010 || bus_if.BUS_DATA_OE !== 1'b0) begin
      errors++; $display("FAIL we_re_same_cycle: got reg=%h pulse=%b oe=%b expected reg=00a51100 pulse=0010 oe=0", REG_OUT, REG_WR_PULSE, bus_if.BUS_DATA_OE);
    end
    bus_idle();
    tick();
    $display("test_out_of_range: done");
  endtask

  task automatic test_event_irq();
    drive_write(8'h95, 8'h08);
    tick();
    bus_idle();
    EVENT_IN = 8'h08;
    tick();
    checks++;
    if (IRQ !== 1'b0) begin
      errors++; $display("FAIL irq_lag: got %b expected 0", IRQ);
    end
    drive_read(8'h94);
    tick();
    checks++;
    if (IRQ !== 1'b1 || bus_if.BUS_DATA_OE !== 1'b1 || bus_if.BUS_DATA_OUT !== 8'h08) begin
      errors++; $display("FAIL event3_status_irq: got irq=%b oe=%b data=%h expected irq=1 oe=1 data=08", IRQ, bus_if.BUS_DATA_OE, bus_if.BUS_DATA_OUT);
    end
    drive_write(8'h94, 8'h08);
    tick();
    checks++;
    if (IRQ !== 1'b1) begin
      errors++; $display("FAIL irq_after_clear_edge: got %b expected 1", IRQ);
    end
    bus_idle();
    tick();
    checks++;
    if (IRQ !== 1'b0) begin
      errors++; $display("FAIL irq_cleared: got %b expected 0", IRQ);
    end
    drive_read(8'h94);
    tick();
    checks++;
    if (bus_if.BUS_DATA_OUT !== 8'h00 || bus_if.BUS_DATA_OE !== 1'b1) begin
      errors++; $display("FAIL status_cleared: got oe=%b data=%h expected oe=1 data=00", bus_if.BUS_DATA_OE, bus_if.BUS_DATA_OUT);
    end
    bus_idle();
    EVENT_IN = 8'h09;
    tick();
    tick();
    tick();
    checks++;
    if (IRQ !== 1'b0) begin
      errors++; $display("FAIL unmasked_event_irq: got %b expected 0", IRQ);
    end
    drive_read(8'h94);
    tick();
    checks++;
    if (bus_if.BUS_DATA_OUT !== 8'h01) begin
      errors++; $display("FAIL unmasked_event_status: got %h expected 01", bus_if.BUS_DATA_OUT);
    end
    bus_idle();
    tick();
    $display("test_event_irq: done");
  endtask

  task automatic test_set_clear_same_cycle();
    drive_write(8'h94, 8'hFF);
    tick();
    EVENT_IN = 8'h0B;
    drive_write(8'h94, 8'h02);
    tick();
    bus_idle();
    drive_read(8'h94);
    tick();
    checks++;
    if (bus_if.BUS_DATA_OUT !== 8'h02) begin
      errors++; $display("FAIL set_wins_over_clear: got %h expected 02", bus_if.BUS_DATA_OUT);
    end
    bus_idle();
    EVENT_IN = 8'hF0;
    RESET    = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    tick();
    drive_read(8'h94);
    tick();
    checks++;
    if (bus_if.BUS_DATA_OE !== 1'b1 || bus_if.BUS_DATA_OUT !== 8'h00 || IRQ !== 1'b0) begin
      errors++; $display("FAIL high_through_reset: got oe=%b data=%h irq=%b expected oe=1 data=00 irq=0", bus_if.BUS_DATA_OE, bus_if.BUS_DATA_OUT, IRQ);
    end
    bus_idle();
    tick();
    checks++;
    if (REG_OUT !== 32'h0) begin
      errors++; $display("FAIL reg_after_reset: got %h expected 0", REG_OUT);
    end
    $display("test_set_clear_same_cycle: done");
  endtask

  task automatic test_reset_mid_op();
    drive_write(8'h90, 8'h3C);
    tick();
    checks++;
    if (REG_OUT !== 32'h0000_003C) begin
      errors++; $display("FAIL write_reg0: got %h expected 0000003c", REG_OUT);
    end
    drive_read(8'h90);
    RESET = 1'b1;
    tick();
    checks++;
    if (bus_if.BUS_DATA_OE !== 1'b0 || bus_if.BUS_DATA_OUT !== 8'h00 || REG_OUT !== 32'h0) begin
      errors++; $display("FAIL read_during_reset: got oe=%b data=%h reg=%h expected oe=0 data=00 reg=0", bus_if.BUS_DATA_OE, bus_if.BUS_DATA_OUT, REG_OUT);
    end
    drive_write(8'h91, 8'h55);
    tick();
    checks++;
    if (REG_OUT !== 32'h0 || REG_WR_PULSE !== 4'b0000) begin
      errors++; $display("FAIL write_during_reset: got reg=%h pulse=%b expected reg=0 pulse=0000", REG_OUT, REG_WR_PULSE);
    end
    RESET = 1'b0;
    bus_idle();
    tick();
    checks++;
    if (REG_OUT !== 32'h0 || REG_WR_PULSE !== 4'b0000) begin
      errors++; $display("FAIL after_reset_write: got reg=%h pulse=%b expected reg=0 pulse=0000", REG_OUT, REG_WR_PULSE);
    end
    $display("test_reset_mid_op: done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] wr_val [4];
    logic [7:0] rd_exp [6];
    logic [3:0] exp_pulse;
    wr_val = '{8'h11, 8'h22, 8'h33, 8'h44};
    rd_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      drive_write(8'(8'h90 + i), wr_val[i]);
      tick();
      exp_pulse = 4'(1 << i);
      checks++;
      if (REG_WR_PULSE !== exp_pulse) begin
        errors++; $display("FAIL b2b_pulse_%0d: got %b expected %b", i, REG_WR_PULSE, exp_pulse);
      end
    end
    bus_idle();
    tick();
    checks++;
    if (REG_OUT !== 32'h4433_2211 || REG_WR_PULSE !== 4'b0000) begin
      errors++; $display("FAIL b2b_regs: got reg=%h pulse=%b expected reg=44332211 pulse=0000", REG_OUT, REG_WR_PULSE);
    end
    for (int i = 0; i < 6; i++) begin
      drive_read(8'(8'h90 + i));
      tick();
      checks++;
      if (bus_if.BUS_DATA_OE !== 1'b1 || bus_if.BUS_DATA_OUT !== rd_exp[i]) begin
        errors++; $display("FAIL b2b_read_%0d: got oe=%b data=%h expected oe=1 data=%h", i, bus_if.BUS_DATA_OE, bus_if.BUS_DATA_OUT, rd_exp[i]);
      end
    end
    bus_idle();
    tick();
    checks++;
    if (bus_if.BUS_DATA_OE !== 1'b0 || bus_if.BUS_DATA_OUT !== 8'h00) begin
      errors++; $display("FAIL b2b_idle: got oe=%b data=%h expected oe=0 data=00", bus_if.BUS_DATA_OE, bus_if.BUS_DATA_OUT);
    end
    $display("test_back_to_back: done");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_event_irq();
    test_set_clear_same_cycle();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
